vga_mem_arbiter: RTL and testbench
==================================

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 3, meaning pixel data width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning CPU write-queue entries (power of 2, at least 2).
REQ-003 SHALL have port clk  in  1  system clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port cpu_we  in  1  CPU pixel-write request.
REQ-006 SHALL have ports cpu_x, cpu_y  in  8 each  CPU pixel coordinates.
REQ-007 SHALL have port cpu_data  in  DATA_W  CPU pixel value.
REQ-008 SHALL have port cpu_ready  out  1  high when the queue is not full.
REQ-009 SHALL have port scan_req  in  1  scan-out read request, one pixel per cycle.
REQ-010 SHALL have ports scan_x, scan_y  in  8 each  scan-out coordinates.
REQ-011 SHALL have port scan_data  out  DATA_W  pixel returned to scan-out.
REQ-012 SHALL have port scan_valid  out  1  scan_data qualifier.
REQ-013 SHALL have ports mem_addr  out  16  ({y,x}); mem_we  out  1; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W.
REQ-014 SHALL have ports pending  out  $clog2(FIFO_DEPTH)+1  queue occupancy; ovf  out  1  sticky overflow flag.

Function
REQ-015 SHALL accept a write into the queue tail on each rising edge where cpu_we=1 and cpu_ready=1.
REQ-016 SHALL drop a write where cpu_we=1 and cpu_ready=0, and SHALL set ovf to 1 on that edge.
REQ-017 SHALL run a three-state FSM giving the memory-port owner for the next cycle: IDLE, RD or WR.
REQ-018 SHALL select the next state on each edge as follows: scan_req=1 gives RD; otherwise a non-empty queue gives WR; otherwise IDLE.
REQ-019 SHALL give scan_req absolute priority, so writes drain only in cycles without scan_req.
REQ-020 SHALL, in state RD, drive mem_addr={scan_y,scan_x} registered from the request cycle, with mem_we=0.
REQ-021 SHALL, in state WR, pop the queue head and drive mem_addr/mem_wdata from it with mem_we=1 for exactly one cycle.
REQ-022 SHALL treat the memory as synchronous-read: mem_rdata is valid the cycle after RD.
REQ-023 SHALL assert scan_valid in cycle k+2 for scan_req=1 in cycle k; scan_data SHALL hold its last value while scan_valid=0.
REQ-024 SHALL allow push and pop on the same edge, leaving pending unchanged.
REQ-025 SHALL provide no bypass: a write pushed in cycle k reaches memory no earlier than cycle k+1.
REQ-026 SHALL issue writes to memory in acceptance order.
REQ-027 SHALL wrap the queue pointers modulo FIFO_DEPTH.
REQ-028 SHALL drive cpu_ready = (pending != FIFO_DEPTH) as a registered-state function.

Reset
REQ-029 SHALL, on reset=1 at any time, immediately force: FSM to IDLE, queue empty (pending=0), cpu_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, scan_valid=0, scan_data=0, ovf=0.
REQ-030 SHALL discard queued writes and in-flight reads on reset mid-operation, with no memory write after reset deasserts until a new cpu_we.

Configuration
REQ-031 SHALL, with VGA_ARB_FWD_EN defined, override the RD result when {scan_y,scan_x} matches any queued entry at the RD cycle: scan_data SHALL then be the youngest matching entry's data, with latency unchanged.
REQ-032 SHALL, without VGA_ARB_FWD_EN, return memory contents only, so stale pixels are possible while writes are queued.

Verification
REQ-033 SHALL verify: reset; scan_req=0; write (x=5,y=2,data=3) -> WR next cycle with mem_addr=16'h0205, mem_wdata=3, mem_we=1 for 1 cycle; pending returns to 0.
REQ-034 SHALL verify: 5 consecutive writes while scan_req=1 with FIFO_DEPTH=4 -> cpu_ready=0 after the 4th write, 5th write dropped, ovf=1; after scan_req=0, 4 writes emitted in order.
REQ-035 SHALL verify: scan_req=1 for cycles 10..13 at x=0..3 -> scan_valid=1 in cycles 12..15 with the memory data for each address.
REQ-036 SHALL verify: simultaneous cpu_we and WR pop with pending=2 -> pending stays 2.
REQ-037 SHALL verify: reset pulse while pending=3 and RD in flight -> all outputs at reset values, and no mem_we after release.
REQ-038 SHALL verify, with VGA_ARB_FWD_EN: write (7,7,data=5) queued and scan_req held at (7,7) -> scan_data=5; without the macro -> the old memory value.

Source files
------------

// File: rtl/vga_mem_arbiter.sv
// Arbitrates one synchronous-read pixel memory between scan-out reads (always first) and a CPU write queue.
// Define VGA_ARB_FWD_EN to forward queued, not-yet-written pixels to scan-out reads of the same address.
module vga_mem_arbiter #(
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cpu_we,
  input  logic [7:0]                      cpu_x,
  input  logic [7:0]                      cpu_y,
  input  logic [DATA_W-1:0]               cpu_data,
  output logic                            cpu_ready,
  input  logic                            scan_req,
  input  logic [7:0]                      scan_x,
  input  logic [7:0]                      scan_y,
  output logic [DATA_W-1:0]               scan_data,
  output logic                            scan_valid,
  output logic [15:0]                     mem_addr,
  output logic                            mem_we,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic [DATA_W-1:0]               mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]     pending,
  output logic                            ovf
);

  // state  | meaning
  // S_IDLE | memory port unused this cycle
  // S_RD   | scan-out read address on the port
  // S_WR   | queue head being written to memory
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t state, state_nxt;

  logic [15:0]       q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop;
  logic              rd_valid;
  logic [DATA_W-1:0] scan_hold;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign cpu_ready  = (count != CNT_W'(FIFO_DEPTH));
  assign push       = cpu_we && cpu_ready;
  assign pop        = (state_nxt == S_WR);
  assign pending    = count;
  assign scan_valid = rd_valid;
  assign scan_data  = rd_valid ? (fwd_hit ? fwd_data : mem_rdata) : scan_hold;

  // The decision uses the registered count, so a write pushed on this edge cannot be popped on it.
  always_comb begin
    state_nxt = S_IDLE;
    if (scan_req)
      state_nxt = S_RD;
    else if (count != '0)
      state_nxt = S_WR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (cpu_we && !cpu_ready)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= {cpu_y, cpu_x};
      q_data[wr_ptr] <= cpu_data;
    end
  end

  // Port outputs are registered for the state being entered, so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      rd_valid  <= 1'b0;
      scan_hold <= '0;
    end else begin
      rd_valid <= (state == S_RD);
      if (rd_valid)
        scan_hold <= scan_data;
      case (state_nxt)
        S_RD: begin
          mem_addr <= {scan_y, scan_x};
          mem_we   <= 1'b0;
        end
        S_WR: begin
          mem_addr  <= q_addr[rd_ptr];
          mem_wdata <= q_data[rd_ptr];
          mem_we    <= 1'b1;
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

`ifdef VGA_ARB_FWD_EN
  logic              fwd_hit_nxt;
  logic [DATA_W-1:0] fwd_data_nxt;
  logic [PTR_W-1:0]  fwd_idx;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit_nxt  = 1'b0;
    fwd_data_nxt = '0;
    fwd_idx      = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (q_addr[fwd_idx] == mem_addr)) begin
        fwd_hit_nxt  = 1'b1;
        fwd_data_nxt = q_data[fwd_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else begin
      fwd_hit  <= (state == S_RD) && fwd_hit_nxt;
      fwd_data <= fwd_data_nxt;
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench for vga_mem_arbiter: a behavioural synchronous-read memory plus write/read expectation queues.
module tb_vga_mem_arbiter;
  localparam int DATA_W = 3;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_we = 1'b0;
  logic [7:0]        cpu_x = '0, cpu_y = '0;
  logic [DATA_W-1:0] cpu_data = '0;
  logic              cpu_ready;
  logic              scan_req = 1'b0;
  logic [7:0]        scan_x = '0, scan_y = '0;
  logic [DATA_W-1:0] scan_data;
  logic              scan_valid;
  logic [15:0]       mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [2:0]        pending;
  logic              ovf;

  vga_mem_arbiter #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst), .cpu_we(cpu_we), .cpu_x(cpu_x), .cpu_y(cpu_y),
    .cpu_data(cpu_data), .cpu_ready(cpu_ready), .scan_req(scan_req),
    .scan_x(scan_x), .scan_y(scan_y), .scan_data(scan_data), .scan_valid(scan_valid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pending(pending), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] a; logic [DATA_W-1:0] d; } wr_t;
  typedef struct packed { int cyc; logic [DATA_W-1:0] d; } rd_t;

  wr_t wr_q[$];
  rd_t rd_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  logic [DATA_W-1:0] mem [0:65535];
  logic [DATA_W-1:0] last_scan = '0;

  function automatic logic [DATA_W-1:0] pat(input logic [15:0] a);
    return a[2:0] + {1'b0, a[9:8]} + 3'd1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Scoreboard monitor: write order, read latency/data, scan_data hold.
  always @(negedge clk) begin
    if (rst) begin
      last_scan = '0;
    end else begin
      if (mem_we) begin
        n_cmp++;
        if (wr_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got addr=%h data=%0d, required none", mem_addr, mem_wdata);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          if ({mem_addr, mem_wdata} !== {w.a, w.d}) begin
            n_bad++;
            $display("FAIL write_order: got addr=%h data=%0d, required addr=%h data=%0d",
                     mem_addr, mem_wdata, w.a, w.d);
          end
        end
      end
      n_cmp++;
      if (scan_valid) begin
        if (rd_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_scan_valid: got data=%0d at cycle %0d, required none", scan_data, cyc);
        end else begin
          rd_t r;
          r = rd_q.pop_front();
          if (cyc !== r.cyc || scan_data !== r.d) begin
            n_bad++;
            $display("FAIL scan_read: got cycle=%0d data=%0d, required cycle=%0d data=%0d",
                     cyc, scan_data, r.cyc, r.d);
          end
        end
        last_scan = scan_data;
      end else if (scan_data !== last_scan) begin
        n_bad++;
        $display("FAIL scan_hold: got %0d, required %0d", scan_data, last_scan);
      end
    end
  end

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic drive(input logic we, input logic [7:0] x, input logic [7:0] y,
                       input logic [DATA_W-1:0] d, input logic acc,
                       input logic sr, input logic [7:0] sx, input logic [7:0] sy,
                       input logic [DATA_W-1:0] rexp);
    cpu_we = we; cpu_x = x; cpu_y = y; cpu_data = d;
    scan_req = sr; scan_x = sx; scan_y = sy;
    if (we && acc) wr_q.push_back('{a: {y, x}, d: d});
    if (sr) rd_q.push_back('{cyc: cyc + 2, d: rexp});
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cpu_we = 1'b0; scan_req = 1'b0;
  endtask

  task automatic drain(input string name);
    idle();
    for (int n = 0; n < 30 && (wr_q.size() != 0 || rd_q.size() != 0); n++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain_timeout: got %0d writes %0d reads outstanding, required 0", name, wr_q.size(), rd_q.size());
    end
  endtask

  task automatic test_reset();
    logic [32:0] got, exp;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {pending, cpu_ready, mem_we, mem_addr, mem_wdata, scan_valid, scan_data, ovf};
    exp = {3'd0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 3'd0, 1'b0};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL reset_state: got %h, required %h", got, exp);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    int n;
    drive(1'b1, 8'd5, 8'd2, 3'd3, 1'b1, 1'b0, 8'd0, 8'd0, 3'd0);
    idle();
    for (n = 0; n < 5 && !mem_we; n++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0205 || mem_wdata !== 3'd3) begin
      n_bad++;
      $display("FAIL single_write: got we=%b addr=%h data=%0d, required we=1 addr=0205 data=3", mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (mem_we !== 1'b0 || pending !== 3'd0) begin
      n_bad++;
      $display("FAIL single_write_after: got we=%b pending=%0d, required we=0 pending=0", mem_we, pending);
    end
    drain("single_write");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      if (i == 3 || i == 4) begin
        n_cmp++;
        if (cpu_ready !== (i == 3)) begin
          n_bad++;
          $display("FAIL ovf_ready_%0d: got %b, required %b", i, cpu_ready, (i == 3));
        end
      end
      drive(1'b1, 8'(10 + i), 8'd3, 3'(i + 1), (i < 4), 1'b1, 8'(i), 8'd1, pat({8'd1, 8'(i)}));
    end
    n_cmp++;
    if (ovf !== 1'b1 || pending !== 3'd4 || cpu_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL overflow_flag: got ovf=%b pending=%0d ready=%b, required ovf=1 pending=4 ready=0", ovf, pending, cpu_ready);
    end
    drain("overflow");
    n_cmp++;
    if (pending !== 3'd0 || ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_after: got pending=%0d ovf=%b, required pending=0 ovf=1", pending, ovf);
    end
  endtask

  task automatic test_scan_burst();
    for (int i = 0; i < 4; i++)
      drive(1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b1, 8'(i), 8'd0, pat({8'd0, 8'(i)}));
    drain("scan_burst");
  endtask

  task automatic test_push_pop();
    drive(1'b1, 8'd20, 8'd4, 3'd6, 1'b1, 1'b1, 8'd4, 8'd1, pat(16'h0104));
    drive(1'b1, 8'd21, 8'd4, 3'd7, 1'b1, 1'b1, 8'd5, 8'd1, pat(16'h0105));
    n_cmp++;
    if (pending !== 3'd2) begin
      n_bad++;
      $display("FAIL push_pop_pre: got pending=%0d, required 2", pending);
    end
    drive(1'b1, 8'd22, 8'd4, 3'd1, 1'b1, 1'b0, 8'd0, 8'd0, 3'd0);
    n_cmp++;
    if (pending !== 3'd2) begin
      n_bad++;
      $display("FAIL push_pop_same_edge: got pending=%0d, required 2", pending);
    end
    drain("push_pop");
  endtask

  task automatic test_reset_midop();
    logic [32:0] got, exp;
    for (int i = 0; i < 3; i++)
      drive(1'b1, 8'(30 + i), 8'd5, 3'(i + 2), 1'b1, 1'b1, 8'(6 + i), 8'd1, pat({8'd1, 8'(6 + i)}));
    n_cmp++;
    if (pending !== 3'd3 || scan_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL midop_setup: got pending=%0d valid=%b, required pending=3 valid=1", pending, scan_valid);
    end
    rst = 1'b1;
    #1;
    got = {pending, cpu_ready, mem_we, mem_addr, mem_wdata, scan_valid, scan_data, ovf};
    exp = {3'd0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 3'd0, 1'b0};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL midop_reset_state: got %h, required %h", got, exp);
    end
    wr_q.delete();
    rd_q.delete();
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (mem_we !== 1'b0 || scan_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL midop_after_release: got we=%b valid=%b, required 0 0", mem_we, scan_valid);
      end
    end
  endtask

  task automatic test_forward();
    logic [DATA_W-1:0] exp_rd;
`ifdef VGA_ARB_FWD_EN
    exp_rd = 3'd5;
`else
    exp_rd = pat(16'h0707);
`endif
    drive(1'b1, 8'd7, 8'd7, 3'd5, 1'b1, 1'b1, 8'd7, 8'd7, exp_rd);
    drive(1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b1, 8'd7, 8'd7, exp_rd);
    drive(1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b1, 8'd7, 8'd7, exp_rd);
    drain("forward");
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = pat(16'(a));
    test_reset();
    test_single_write();
    test_overflow();
    test_scan_burst();
    test_push_pop();
    test_reset_midop();
    test_forward();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
